// File: rtl/stream_pkg.sv
// Shared stream types: the handshake state and the join-buffer slot state.
package stream_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_STALL,
    HS_XFER
  } stream_hs_e;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  // Counter width able to hold 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stream_join_slot.sv
// One capture slot of the join buffer: holds a single payload from its input
// until the joined beat containing it is taken downstream.
module stream_join_slot
  import stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              drain_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  slot_state_e       state;
  logic [DATA_W-1:0] data_q;

  // A draining slot can be refilled in the same cycle, so ready includes drain.
  assign ready_o = (state == SLOT_EMPTY) | drain_i;
  assign full_o  = (state == SLOT_FULL);
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= SLOT_EMPTY;
      data_q <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (valid_i) begin
            state  <= SLOT_FULL;
            data_q <= data_i;
          end
        end
        SLOT_FULL: begin
          if (drain_i) begin
            if (valid_i) begin
              data_q <= data_i;
            end else begin
              state <= SLOT_EMPTY;
            end
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/stream_join_buf.sv
// Joins N_INP valid/ready streams into one beat carrying every input's payload.
// Optional skew-stall watchdog enabled by defining STREAM_JOIN_BUF_STALL_EN.
module stream_join_buf
  import stream_pkg::*;
#(
  parameter int N_INP  = 2,
  parameter int DATA_W = 8
`ifdef STREAM_JOIN_BUF_STALL_EN
  ,
  parameter int STALL_MAX = 255
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_INP-1:0]        valid_i,
  output logic [N_INP-1:0]        ready_o,
  input  logic [N_INP*DATA_W-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [N_INP*DATA_W-1:0] data_o
`ifdef STREAM_JOIN_BUF_STALL_EN
  ,
  output logic                    stall_err_o
`endif
);

  logic [N_INP-1:0] full;
  logic             drain;

  // valid_o depends only on slot state; ready_i reaches ready_o through drain.
  assign valid_o = &full;
  assign drain   = valid_o & ready_i;

  for (genvar g = 0; g < N_INP; g++) begin : g_slot
    stream_join_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .valid_i(valid_i[g]),
      .data_i (data_i[g*DATA_W +: DATA_W]),
      .drain_i(drain),
      .ready_o(ready_o[g]),
      .full_o (full[g]),
      .data_o (data_o[g*DATA_W +: DATA_W])
    );
  end

`ifdef STREAM_JOIN_BUF_STALL_EN
  localparam int               CNT_W     = cnt_width(STALL_MAX);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall_err_q;
  logic             partial;

  // Some inputs have arrived while others are still missing.
  assign partial     = (|full) & ~(&full);
  assign stall_err_o = stall_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt   <= '0;
      stall_err_q <= 1'b0;
    end else if (partial) begin
      if (stall_cnt != STALL_LIM) begin
        stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt + 1'b1 == STALL_LIM) begin
          stall_err_q <= 1'b1;
        end
      end
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stream_join_buf.sv
// Bench for stream_join_buf: directed join scenarios on a 2-input instance and
// queue-model random traffic on a 3-input instance.
module tb_stream_join_buf;

  logic        clk;
  logic        rst;
  logic [1:0]  v2, r2o;
  logic [15:0] d2i, do2;
  logic        vo2, ri2;
  logic [2:0]  v3, r3o;
  logic [23:0] d3i, do3;
  logic        vo3, ri3;
`ifdef STREAM_JOIN_BUF_STALL_EN
  logic        err2, err3;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [3][$];

  stream_join_buf #(
    .N_INP (2),
    .DATA_W(8)
`ifdef STREAM_JOIN_BUF_STALL_EN
    ,
    .STALL_MAX(4)
`endif
  ) u_dut2 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(v2),
    .ready_o(r2o),
    .data_i (d2i),
    .valid_o(vo2),
    .ready_i(ri2),
    .data_o (do2)
`ifdef STREAM_JOIN_BUF_STALL_EN
    ,
    .stall_err_o(err2)
`endif
  );

  stream_join_buf #(
    .N_INP (3),
    .DATA_W(8)
  ) u_dut3 (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(v3),
    .ready_o(r3o),
    .data_i (d3i),
    .valid_o(vo3),
    .ready_i(ri3),
    .data_o (do3)
`ifdef STREAM_JOIN_BUF_STALL_EN
    ,
    .stall_err_o(err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    v2 = '0; d2i = '0; ri2 = 1'b0;
    v3 = '0; d3i = '0; ri3 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    total++; if (vo2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid2: got %b expected 0", vo2); end
    total++; if (do2 !== 16'h0) begin bad++; $display("[TB] FAIL reset_data2: got %h expected 0000", do2); end
    total++; if (r2o !== 2'b11) begin bad++; $display("[TB] FAIL reset_ready2: got %b expected 11", r2o); end
    total++; if (vo3 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid3: got %b expected 0", vo3); end
    total++; if (r3o !== 3'b111) begin bad++; $display("[TB] FAIL reset_ready3: got %b expected 111", r3o); end
`ifdef STREAM_JOIN_BUF_STALL_EN
    total++; if (err2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_err2: got %b expected 0", err2); end
`endif
  endtask

  // inp0 in cycle 1, inp1 in cycle 4; joined beat only in cycle 5.
  task automatic test_join_skew;
    do_reset;
    ri2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      v2  = (c == 1) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      d2i = (c == 1) ? 16'h00A5 : (c == 4) ? 16'h3C00 : 16'hFFFF;
      #1;
      total++;
      if (vo2 !== (c == 5)) begin bad++; $display("[TB] FAIL skew_valid c%0d: got %b expected %b", c, vo2, (c == 5)); end
      if (c >= 2 && c <= 4) begin
        total++;
        if (r2o[0] !== 1'b0) begin bad++; $display("[TB] FAIL skew_ready0 c%0d: got %b expected 0", c, r2o[0]); end
      end
      if (c == 5) begin
        total++;
        if (do2 !== 16'h3CA5) begin bad++; $display("[TB] FAIL skew_data: got %h expected 3ca5", do2); end
      end
      tick;
    end
  endtask

  function automatic logic [23:0] inc_word(input int c);
    return {8'(c * 3 + 2), 8'(c * 3 + 1), 8'(c * 3)};
  endfunction

  task automatic test_throughput;
    int beats;
    do_reset;
    beats = 0;
    ri3 = 1'b1;
    v3  = 3'b111;
    for (int c = 0; c < 100; c++) begin
      d3i = inc_word(c);
      #1;
      if (c >= 1) begin
        total++;
        if (vo3 !== 1'b1 || do3 !== inc_word(c - 1)) begin
          bad++;
          $display("[TB] FAIL tput_beat c%0d: got v=%b d=%h expected v=1 d=%h", c, vo3, do3, inc_word(c - 1));
        end
      end
      if (vo3 === 1'b1) beats++;
      tick;
    end
    total++;
    if (beats != 99) begin bad++; $display("[TB] FAIL tput_count: got %0d expected 99", beats); end
    v3 = '0;
    tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    ri2 = 1'b0;
    v2  = 2'b11;
    d2i = 16'h1122;
    tick;
    for (int k = 0; k < 5; k++) begin
      d2i = 16'(16'hA000 + k * 16'h0101);
      #1;
      total++;
      if (vo2 !== 1'b1 || do2 !== 16'h1122 || r2o !== 2'b00) begin
        bad++;
        $display("[TB] FAIL hold k%0d: got v=%b d=%h r=%b expected v=1 d=1122 r=00", k, vo2, do2, r2o);
      end
      tick;
    end
    ri2 = 1'b1;
    d2i = 16'h7788;
    #1;
    total++;
    if (r2o !== 2'b11 || do2 !== 16'h1122) begin bad++; $display("[TB] FAIL release: got r=%b d=%h expected r=11 d=1122", r2o, do2); end
    tick;
    v2  = 2'b00;
    ri2 = 1'b0;
    #1;
    total++;
    if (vo2 !== 1'b1 || do2 !== 16'h7788) begin bad++; $display("[TB] FAIL refill: got v=%b d=%h expected v=1 d=7788", vo2, do2); end
    ri2 = 1'b1;
    tick;
    #1;
    total++;
    if (vo2 !== 1'b0) begin bad++; $display("[TB] FAIL drained: got %b expected 0", vo2); end
  endtask

  task automatic test_reset_partial;
    do_reset;
    ri2 = 1'b1;
    v2  = 2'b01;
    d2i = 16'h0055;
    tick;
    rst = 1'b1;
    v2  = 2'b00;
    tick;
    rst = 1'b0;
    #1;
    total++;
    if (vo2 !== 1'b0 || r2o !== 2'b11) begin bad++; $display("[TB] FAIL rstp_after: got v=%b r=%b expected v=0 r=11", vo2, r2o); end
    v2  = 2'b10;
    d2i = 16'h6600;
    #1;
    total++;
    if (vo2 !== 1'b0) begin bad++; $display("[TB] FAIL rstp_no_beat: got %b expected 0", vo2); end
    tick;
    v2  = 2'b01;
    d2i = 16'h0099;
    #1;
    total++;
    if (vo2 !== 1'b0 || r2o !== 2'b01) begin bad++; $display("[TB] FAIL rstp_partial: got v=%b r=%b expected v=0 r=01", vo2, r2o); end
    tick;
    v2 = 2'b00;
    #1;
    total++;
    if (vo2 !== 1'b1 || do2 !== 16'h6699) begin bad++; $display("[TB] FAIL rstp_beat: got v=%b d=%h expected v=1 d=6699", vo2, do2); end
    tick;
  endtask

  task automatic test_stall;
    do_reset;
    ri2 = 1'b1;
    v2  = 2'b01;
    d2i = 16'h0011;
    tick;
    v2 = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      #1;
`ifdef STREAM_JOIN_BUF_STALL_EN
      total++;
      if (err2 !== 1'b0) begin bad++; $display("[TB] FAIL stall_early k%0d: got %b expected 0", k, err2); end
`endif
      tick;
    end
    v2  = 2'b10;
    d2i = 16'h2200;
    #1;
`ifdef STREAM_JOIN_BUF_STALL_EN
    total++;
    if (err2 !== 1'b1) begin bad++; $display("[TB] FAIL stall_set: got %b expected 1", err2); end
`endif
    tick;
    v2 = 2'b00;
    #1;
    total++;
    if (vo2 !== 1'b1 || do2 !== 16'h2211) begin bad++; $display("[TB] FAIL stall_beat: got v=%b d=%h expected v=1 d=2211", vo2, do2); end
    tick;
`ifdef STREAM_JOIN_BUF_STALL_EN
    total++;
    if (err2 !== 1'b1) begin bad++; $display("[TB] FAIL stall_sticky: got %b expected 1", err2); end
`endif
  endtask

  // Each input's accepted payloads queue up; a beat joins the queue heads.
  task automatic test_random;
    logic       ev, fire;
    logic [2:0] er;
    do_reset;
    for (int i = 0; i < 3; i++) mq[i].delete();
    for (int c = 0; c < 400; c++) begin
      v3  = 3'($urandom_range(0, 7));
      d3i = 24'($urandom);
      ri3 = ($urandom_range(0, 3) != 0);
      #1;
      ev = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0);
      for (int i = 0; i < 3; i++) er[i] = (mq[i].size() == 0) || (ev && ri3);
      total++;
      if (vo3 !== ev || r3o !== er) begin
        bad++;
        $display("[TB] FAIL rand_hs c%0d: got v=%b r=%b expected v=%b r=%b", c, vo3, r3o, ev, er);
      end
      if (ev) begin
        total++;
        if (do3 !== {mq[2][0], mq[1][0], mq[0][0]}) begin
          bad++;
          $display("[TB] FAIL rand_data c%0d: got %h expected %h", c, do3, {mq[2][0], mq[1][0], mq[0][0]});
        end
      end
      fire = ev && ri3;
      for (int i = 0; i < 3; i++) begin
        if (fire) void'(mq[i].pop_front());
        if (v3[i] && er[i]) mq[i].push_back(d3i[i*8 +: 8]);
      end
      tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    v2 = '0; d2i = '0; ri2 = 1'b0;
    v3 = '0; d3i = '0; ri3 = 1'b0;
    test_reset;
    test_join_skew;
    test_throughput;
    test_back_to_back;
    test_reset_partial;
    test_stall;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
